// File: rtl/weighted_fifo_dispatcher_pkg.sv
// Shared types and sizing helpers for the weighted round-robin dispatcher.
package dispatch_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    SEND = 1'b1
  } state_e;

  // Pointer and occupancy widths for a lane FIFO of the given depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/weighted_fifo_dispatcher_if.sv
// Input ready/valid stream feeding the dispatcher.
interface weighted_fifo_dispatcher_if #(
  parameter int WIDTH = 8
);
  logic             push;
  logic [WIDTH-1:0] data_in;
  logic             ready;

  modport master (output push, output data_in, input ready);
  modport slave  (input push, input data_in, output ready);
endinterface

// File: rtl/weighted_fifo_dispatcher_lane_fifo.sv
// Show-ahead lane FIFO; head reads as zero while empty, full uses registered count only.
module lane_fifo
  import dispatch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/weighted_fifo_dispatcher.sv
// Distributes one input stream into NUM_REQS lane FIFOs by weighted round-robin.
module weighted_fifo_dispatcher
  import dispatch_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int QWID     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  weighted_fifo_dispatcher_if.slave     bus,
  input  logic [NUM_REQS*QWID-1:0]      quantums,
  input  logic [NUM_REQS-1:0]           pop,
  output logic [NUM_REQS*WIDTH-1:0]     flat_data_out,
  output logic [NUM_REQS-1:0]           empty,
  output logic [NUM_REQS-1:0]           full,
  output logic [$clog2(NUM_REQS)-1:0]   sel
);
  localparam int SW = $clog2(NUM_REQS);

  state_e              state;
  logic [QWID-1:0]     cnt;
  logic [QWID-1:0]     quantum [NUM_REQS];
  logic [QWID-1:0]     q_sel;
  logic [NUM_REQS-1:0] lane_push;
  logic                accept;

  function automatic logic [SW-1:0] next_lane(input logic [SW-1:0] s);
    return (s == SW'(NUM_REQS - 1)) ? '0 : s + SW'(1);
  endfunction

  assign q_sel     = quantum[sel];
  assign bus.ready = (state == SEND) && !full[sel];
  assign accept    = bus.push && bus.ready;

  genvar i;
  generate
    for (i = 0; i < NUM_REQS; i++) begin : g_lane
      assign quantum[i]   = quantums[i*QWID +: QWID];
      assign lane_push[i] = accept && (sel == SW'(i));

      lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (lane_push[i]),
        .pop      (pop[i]),
        .data_in  (bus.data_in),
        .data_out (flat_data_out[i*WIDTH +: WIDTH]),
        .empty    (empty[i]),
        .full     (full[i])
      );
    end
  endgenerate

  // A full lane stalls the stream rather than being skipped, so lane order stays fixed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      sel   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        LOAD: begin
          cnt <= q_sel;
          if (q_sel == '0) sel <= next_lane(sel);
          else             state <= SEND;
        end
        SEND: begin
          if (accept) begin
            cnt <= cnt - QWID'(1);
            if (cnt == QWID'(1)) begin
              sel   <= next_lane(sel);
              state <= LOAD;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: doc/weighted_fifo_dispatcher.md
# weighted_fifo_dispatcher

Write-side counterpart of the arbitrated FIFO merger. It takes one ready/valid input stream and distributes words into `NUM_REQS` lane FIFOs by weighted round-robin, with per-lane burst lengths given by `quantums`. Each lane is drained independently by its own `pop`. Lane order is deterministic, so a scoreboard can predict the destination lane of every input word.

## Interface
- `NUM_REQS`, default 4: number of lanes; ≥2.
- `WIDTH`, default 8: data width.
- `DEPTH`, default 8: words per lane FIFO; power of 2, ≥2.
- `QWID`, default 4: quantum width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `push` in 1: input word valid.
- `data_in` in `WIDTH`: input word.
- `ready` out 1: word accepted on a cycle with `push && ready`.
- `quantums` in `NUM_REQS*QWID`: lane i burst length at bits `[(i+1)*QWID-1:i*QWID]`.
- `pop` in `NUM_REQS`: per-lane read strobe.
- `flat_data_out` out `NUM_REQS*WIDTH`: head word of each lane, show-ahead; 0 when the lane is empty.
- `empty` out `NUM_REQS`: lane empty.
- `full` out `NUM_REQS`: lane holds `DEPTH` words.
- `sel` out `$clog2(NUM_REQS)`: lane currently being written.

## Operation
- FSM states:
  - LOAD:
    - `ready`=0.
    - `cnt <= quantum[sel]`.
    - If `quantum[sel]`==0: `sel <= sel+1` (mod `NUM_REQS`), stay in LOAD.
    - Otherwise go to SEND.
  - SEND:
    - `ready = !full[sel]`.
    - On accept: word is written to lane `sel` and `cnt` decrements.
    - Accept with `cnt`==1: `sel <= sel+1` (mod `NUM_REQS`), go to LOAD.
- A full lane stalls the input; it is never skipped. This keeps ordering strictly deterministic.
- Quantum is sampled only in LOAD. Changes during SEND take effect at the lane's next turn.
- All quantums zero: `ready` stays 0 and `sel` advances every cycle.
- Lane FIFO:
  - `DEPTH` entries, read and write pointers of `$clog2(DEPTH)` bits that wrap naturally.
  - Occupancy counter is `$clog2(DEPTH)+1` bits.
- `pop` on an empty lane is ignored: no pointer or count change.
- `full` is computed from the registered count only. A simultaneous pop does not make room for a same-cycle push.

## Timing
- Reset values (asynchronous): state LOAD, `sel`=0, `cnt`=0, all lanes empty, `ready`=0, `empty`=all 1, `full`=all 0, `flat_data_out`=0.
- First LOAD after reset release takes one cycle, so the earliest accept is cycle 2 after release.
- Each turn costs one LOAD bubble cycle, plus one cycle per zero-quantum lane skipped.
- Write latency: a word accepted at edge t is visible at the lane head, with `empty` deasserted, after edge t, i.e. at cycle t+1.
- Pop at edge t: the next word or the empty indication is visible after edge t.
- Push and pop on the same non-full lane in one cycle: count unchanged, both pointers advance.
- Push and pop on a lane holding 1 word: the lane stays non-empty and the head becomes the new word.
- Reset mid-operation: contents are discarded, all outputs return to reset values immediately, and the FSM restarts at lane 0.

## Structure
- Package `dispatch_pkg`:
  - FSM state enum `{LOAD, SEND}`.
  - Helper localparams for pointer and count widths.
- Sub-module `lane_fifo`: show-ahead FIFO with push, pop, data, empty and full. Instantiate it `NUM_REQS` times in a generate loop.
- The top level holds the FSM, `sel`/`cnt` registers, quantum unpack and the push demux.

## Test plan
- Quantums {1,2,3,1} (lanes 0..3), `push` held high, data 1..14 → lane0={1,8}, lane1={2,3,9,10}, lane2={4,5,6,11,12,13}, lane3={7,14}. `ready` low one cycle at each turn change.
- Quantums {2,0,0,2}, 6 pushes → lanes 1 and 2 are skipped, each costing one extra LOAD cycle. Lane0={1,2,5,6}, lane3={3,4}.
- `DEPTH`=8, quantum0=15, no pops → after 8 accepts `full[0]`=1 and `ready`=0. Stalls until one `pop[0]`, then the 9th word is accepted the following cycle.
- `pop` on an empty lane, then push and pop on the same lane holding 1 word → no underflow, count stays 1, `flat_data_out` shows the newer word.
- Reset asserted mid-SEND with 3 words buffered → `empty`=all 1, `sel`=0, `ready`=0 in the same cycle. After release, the first accepted word goes to lane 0.
- All quantums 0 → `ready` never asserts, `sel` cycles 0,1,2,3,0….
